// File: rtl/store_buffer.sv
// Store formatting and buffering stage ahead of the data-memory write port.
// Formats SB/SH/SW/SD into lane-aligned data and strobes, queues them in a FIFO.
module store_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_size_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              misaligned_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,
    input  logic [XLEN-1:0]   ld_addr_i,
    output logic              ld_hazard_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic              empty_o
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    logic [OFFW-1:0] off;
    logic [NB-1:0]   f_strb;
    logic [XLEN-1:0] f_raw;
    logic [XLEN-1:0] f_data;
    logic [XLEN-1:0] f_addr;
    logic [XLEN-1:0] ld_al;
    logic            bad;
    logic            enq;
    logic            deq;

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [NB-1:0]   strb_q [DEPTH];

    logic            unused_ld_off;

    assign off           = req_addr_i[OFFW-1:0];
    assign f_addr        = {req_addr_i[XLEN-1:OFFW], OFFW'(0)};
    assign ld_al         = {ld_addr_i[XLEN-1:OFFW], OFFW'(0)};
    assign unused_ld_off = ^ld_addr_i[OFFW-1:0];

    // Lane-align the store data and build strobes; dead lanes forced to zero.
    always_comb begin
        f_strb = '0;
        f_raw  = '0;
        f_data = '0;
        case (req_size_i)
            2'b00: begin
                f_strb = NB'(1) << off;
                f_raw  = XLEN'(req_wdata_i[7:0]) << {off, 3'b000};
            end
            2'b01: begin
                f_strb = NB'(3) << off;
                f_raw  = XLEN'(req_wdata_i[15:0]) << {off, 3'b000};
            end
            2'b10: begin
                f_strb = NB'(15) << off;
                f_raw  = XLEN'(req_wdata_i[31:0]) << {off, 3'b000};
            end
            default: begin
                f_strb = '1;
                f_raw  = req_wdata_i;
            end
        endcase
        for (int b = 0; b < NB; b++) begin
            f_data[8*b +: 8] = f_strb[b] ? f_raw[8*b +: 8] : 8'h00;
        end
    end

    // Alignment check; a double store is illegal on a 32-bit datapath.
    always_comb begin
        bad = 1'b0;
        case (req_size_i)
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            2'b11:   bad = (XLEN == 32) || (|off);
            default: bad = 1'b0;
        endcase
    end

    assign misaligned_o = req_valid_i & bad;
    assign req_ready_o  = count_q < CW'(DEPTH);
    assign mem_valid_o  = count_q != '0;
    assign empty_o      = count_q == '0;
    assign count_o      = count_q;
    assign enq          = req_valid_i & req_ready_o & ~misaligned_o;
    assign deq          = mem_valid_o & mem_ready_i;

    assign mem_addr_o  = mem_valid_o ? addr_q[head_q] : '0;
    assign mem_wdata_o = mem_valid_o ? data_q[head_q] : '0;
    assign mem_wstrb_o = mem_valid_o ? strb_q[head_q] : '0;

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = deq ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Word-granular RAW check against occupied entries only.
    always_comb begin
        ld_hazard_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == ld_al)) begin
                ld_hazard_o = 1'b1;
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written at the tail on enqueue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
        end else if (enq) begin
            addr_q[tail_q] <= f_addr;
            data_q[tail_q] <= f_data;
            strb_q[tail_q] <= f_strb;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer, XLEN=32 and XLEN=64 instances.
// Expected memory-side entries come from a scoreboard queue per instance.
module tb_store_buffer;
    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_mis, a_mvalid, a_mready, a_haz, a_empty;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata, a_maddr, a_mwdata, a_ld;
    logic [3:0]  a_mstrb;
    logic [2:0]  a_count;

    logic        b_valid, b_ready, b_mis, b_mvalid, b_mready, b_haz, b_empty;
    logic [1:0]  b_size;
    logic [63:0] b_addr, b_wdata, b_maddr, b_mwdata, b_ld;
    logic [7:0]  b_mstrb;
    logic [2:0]  b_count;

    store_buffer #(.XLEN(32), .DEPTH(4)) dut32 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_valid), .req_ready_o(a_ready),
        .req_size_i(a_size), .req_addr_i(a_addr), .req_wdata_i(a_wdata),
        .misaligned_o(a_mis),
        .mem_valid_o(a_mvalid), .mem_ready_i(a_mready),
        .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata), .mem_wstrb_o(a_mstrb),
        .ld_addr_i(a_ld), .ld_hazard_o(a_haz),
        .count_o(a_count), .empty_o(a_empty)
    );

    store_buffer #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_valid), .req_ready_o(b_ready),
        .req_size_i(b_size), .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .misaligned_o(b_mis),
        .mem_valid_o(b_mvalid), .mem_ready_i(b_mready),
        .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata), .mem_wstrb_o(b_mstrb),
        .ld_addr_i(b_ld), .ld_hazard_o(b_haz),
        .count_o(b_count), .empty_o(b_empty)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t q32[$];
    ent_t q64[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put32(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
        a_valid = 1'b1;
        a_size  = sz;
        a_addr  = ad;
        a_wdata = wd;
    endtask

    task automatic put64(input logic [1:0] sz, input logic [63:0] ad, input logic [63:0] wd);
        b_valid = 1'b1;
        b_size  = sz;
        b_addr  = ad;
        b_wdata = wd;
    endtask

    task automatic exp32(input logic [63:0] ad, input logic [63:0] wd, input logic [7:0] st);
        ent_t e;
        e.a = ad;
        e.d = wd;
        e.s = st;
        q32.push_back(e);
    endtask

    task automatic exp64(input logic [63:0] ad, input logic [63:0] wd, input logic [7:0] st);
        ent_t e;
        e.a = ad;
        e.d = wd;
        e.s = st;
        q64.push_back(e);
    endtask

    task automatic head32(input string tag);
        ent_t e;
        chk({tag, "_valid"}, 64'(a_mvalid), 64'd1);
        if (q32.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = q32.pop_front();
            chk({tag, "_addr"}, 64'(a_maddr), e.a);
            chk({tag, "_data"}, 64'(a_mwdata), e.d);
            chk({tag, "_strb"}, 64'(a_mstrb), 64'(e.s));
        end
    endtask

    task automatic head64(input string tag);
        ent_t e;
        chk({tag, "_valid"}, 64'(b_mvalid), 64'd1);
        if (q64.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = q64.pop_front();
            chk({tag, "_addr"}, b_maddr, e.a);
            chk({tag, "_data"}, b_mwdata, e.d);
            chk({tag, "_strb"}, 64'(b_mstrb), 64'(e.s));
        end
    endtask

    task automatic drain32(input string tag);
        head32(tag);
        a_mready = 1'b1;
        tick();
        a_mready = 1'b0;
        #1;
    endtask

    task automatic drain64(input string tag);
        head64(tag);
        b_mready = 1'b1;
        tick();
        b_mready = 1'b0;
        #1;
    endtask

    initial begin
        a_valid = 0; a_size = 0; a_addr = 0; a_wdata = 0; a_mready = 0; a_ld = 0;
        b_valid = 0; b_size = 0; b_addr = 0; b_wdata = 0; b_mready = 0; b_ld = 0;

        // reset state
        tick();
        tick();
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_empty", 64'(a_empty), 64'd1);
        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_mvalid", 64'(a_mvalid), 64'd0);
        chk("rst_maddr", 64'(a_maddr), 64'd0);
        chk("rst_hazard", 64'(a_haz), 64'd0);
        rst = 1'b0;
        tick();

        // SB into top lane, no same-cycle bypass
        put32(2'b00, 32'h1003, 32'h0000_00AB);
        exp32(64'h1000, 64'hAB00_0000, 8'b1000);
        #1;
        chk("sb_mis", 64'(a_mis), 64'd0);
        chk("sb_nobypass", 64'(a_mvalid), 64'd0);
        tick();
        a_valid = 0;
        #1;
        chk("sb_count", 64'(a_count), 64'd1);
        drain32("sb");
        chk("sb_empty", 64'(a_empty), 64'd1);

        // SH into upper half
        put32(2'b01, 32'h1002, 32'h0000_1234);
        exp32(64'h1000, 64'h1234_0000, 8'b1100);
        tick();
        a_valid = 0;
        #1;
        drain32("sh");

        // misalignment
        put32(2'b10, 32'h1002, 32'h1111_1111);
        #1;
        chk("sw_mis", 64'(a_mis), 64'd1);
        tick();
        chk("sw_mis_count", 64'(a_count), 64'd0);
        a_valid = 0;
        #1;
        chk("mis_novalid", 64'(a_mis), 64'd0);
        put32(2'b01, 32'h1001, 32'h2222);
        #1;
        chk("sh_mis", 64'(a_mis), 64'd1);
        put32(2'b11, 32'h1000, 32'h3333);
        #1;
        chk("sd32_mis", 64'(a_mis), 64'd1);
        tick();
        chk("sd32_count", 64'(a_count), 64'd0);
        a_valid = 0;

        // fill with backpressure
        for (int i = 0; i < 4; i++) begin
            put32(2'b10, 32'h3000 + 32'(4*i), 32'hC0DE_0000 + 32'(i));
            exp32(64'h3000 + 64'(4*i), 64'hC0DE_0000 + 64'(i), 8'hF);
            tick();
        end
        chk("full_count", 64'(a_count), 64'd4);
        chk("full_ready", 64'(a_ready), 64'd0);
        put32(2'b10, 32'h3100, 32'hDEAD_0001);
        tick();
        chk("full_5th", 64'(a_count), 64'd4);
        chk("full_stable", 64'(a_maddr), 64'h3000);

        // drain in order; enqueue attempt on the full+dequeue cycle is dropped
        put32(2'b10, 32'h3200, 32'hDEAD_0002);
        for (int i = 0; i < 4; i++) begin
            head32("fifo");
            a_mready = 1'b1;
            tick();
            a_valid = 0;
            #1;
            if (i == 0) begin
                chk("ready_rise", 64'(a_ready), 64'd1);
                chk("full_deq_count", 64'(a_count), 64'd3);
            end
        end
        a_mready = 0;
        #1;
        chk("drain_empty", 64'(a_empty), 64'd1);

        // simultaneous enqueue/dequeue at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            put32(2'b10, 32'h4000 + 32'(4*i), 32'hAA00 + 32'(i));
            exp32(64'h4000 + 64'(4*i), 64'hAA00 + 64'(i), 8'hF);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            put32(2'b10, 32'h4010 + 32'(4*k), 32'h5000 + 32'(k));
            exp32(64'h4010 + 64'(4*k), 64'h5000 + 64'(k), 8'hF);
            #1;
            head32("swap");
            a_mready = 1'b1;
            tick();
            chk("swap_count", 64'(a_count), 64'd2);
        end
        a_valid = 0;
        a_mready = 0;
        #1;
        drain32("wrap0");
        drain32("wrap1");
        chk("wrap_empty", 64'(a_empty), 64'd1);

        // RAW hazard
        put32(2'b10, 32'h2000, 32'h0000_0055);
        exp32(64'h2000, 64'h55, 8'hF);
        a_ld = 32'h2003;
        #1;
        chk("haz_enq_cycle", 64'(a_haz), 64'd0);
        tick();
        a_valid = 0;
        #1;
        chk("haz_hit", 64'(a_haz), 64'd1);
        a_ld = 32'h2004;
        #1;
        chk("haz_miss", 64'(a_haz), 64'd0);
        a_ld = 32'h2003;
        drain32("haz");
        chk("haz_drained", 64'(a_haz), 64'd0);

        // XLEN=64
        put64(2'b11, 64'h08, 64'h1122_3344_5566_7788);
        exp64(64'h08, 64'h1122_3344_5566_7788, 8'hFF);
        #1;
        chk("sd64_mis", 64'(b_mis), 64'd0);
        tick();
        put64(2'b10, 64'h0C, 64'h0000_0000_DEAD_BEEF);
        exp64(64'h08, 64'hDEAD_BEEF_0000_0000, 8'hF0);
        tick();
        put64(2'b11, 64'h04, 64'h99);
        #1;
        chk("sd64_misal", 64'(b_mis), 64'd1);
        tick();
        b_valid = 0;
        #1;
        chk("b_count2", 64'(b_count), 64'd2);
        drain64("sd64");
        drain64("sw64");

        put64(2'b00, 64'h11, 64'h5A);
        tick();
        put64(2'b01, 64'h16, 64'hBEEF);
        tick();
        put64(2'b11, 64'h20, 64'h0123_4567_89AB_CDEF);
        tick();
        b_valid = 0;
        #1;
        chk("b_count3", 64'(b_count), 64'd3);
        chk("sb64_strb", 64'(b_mstrb), 64'h02);
        chk("sb64_data", b_mwdata, 64'h5A00);
        chk("sb64_addr", b_maddr, 64'h10);

        // asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        chk("arst_count", 64'(b_count), 64'd0);
        chk("arst_mvalid", 64'(b_mvalid), 64'd0);
        chk("arst_maddr", b_maddr, 64'd0);
        chk("arst_empty", 64'(b_empty), 64'd1);
        chk("arst_ready", 64'(b_ready), 64'd1);
        q64.delete();
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
